// File: rtl/ps2_scancode_fifo_if.sv
// Bus between the PS/2 scan-code FIFO and its neighbours: byte input from the
// line interface, event output to the consumer, and status/debug signals.
interface ps2_scancode_fifo_if #(
  parameter int AW = 3
);
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_err;
  logic [9:0]  ev_data;
  logic        ev_valid;
  logic        ev_ready;
  logic [AW:0] count;
  logic        overflow;
  logic        ovf_clr;
  logic [7:0]  last_byte;
  logic [1:0]  dec_state;

  // Handshake: ev_data is the FIFO head whenever ev_valid=1; the head is
  // consumed on a rising clk edge where ev_valid && ev_ready. ev_ready while
  // empty has no effect. rx_valid is a level strobe; only its rising edge
  // delivers a byte.
  modport slave (
    input  rx_data, rx_valid, rx_err, ev_ready, ovf_clr,
    output ev_data, ev_valid, count, overflow, last_byte, dec_state
  );

  modport master (
    output rx_data, rx_valid, rx_err, ev_ready, ovf_clr,
    input  ev_data, ev_valid, count, overflow, last_byte, dec_state
  );
endinterface

// File: rtl/ps2_scancode_fifo.sv
// PS/2 scan-code set 2 decoder (E0/F0 prefixes) feeding a show-ahead event FIFO
// with sticky overflow, occupancy count and raw last-byte capture.
module ps2_scancode_fifo #(
  parameter int DEPTH        = 8,
  parameter int AW           = 3,
  parameter bit FILTER_BREAK = 1'b0
) (
  input logic clk,
  input logic reset,
  ps2_scancode_fifo_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_E0   = 2'd1,
    ST_F0   = 2'd2,
    ST_E0F0 = 2'd3
  } dec_state_e;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  dec_state_e    state_q, state_d;
  logic          rx_valid_q;
  logic [7:0]    last_byte_q, last_byte_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [9:0]    mem_q [DEPTH];

  logic accept, ev_emit, push, pop, full, drop, ext, brk;

  always_comb begin
    ext         = (state_q == ST_E0) || (state_q == ST_E0F0);
    brk         = (state_q == ST_F0) || (state_q == ST_E0F0);
    accept      = bus.rx_valid && !rx_valid_q;
    state_d     = state_q;
    ev_emit     = 1'b0;
    last_byte_d = last_byte_q;
    if (accept) last_byte_d = bus.rx_data;
    // A line error abandons any partial prefix and discards a coincident byte.
    if (bus.rx_err) begin
      state_d = ST_IDLE;
    end else if (accept) begin
      case (bus.rx_data)
        8'hE0: begin
          if (state_q == ST_IDLE)    state_d = ST_E0;
          else if (state_q == ST_F0) state_d = ST_E0F0;
        end
        8'hF0: begin
          if (state_q == ST_IDLE)    state_d = ST_F0;
          else if (state_q == ST_E0) state_d = ST_E0F0;
        end
        8'h00, 8'hFF: state_d = ST_IDLE;
        default: begin
          state_d = ST_IDLE;
          ev_emit = !(FILTER_BREAK && brk);
        end
      endcase
    end

    full       = (count_q == FULL_CNT);
    pop        = (count_q != '0) && bus.ev_ready;
    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    push       = ev_emit && (!full || pop);
    drop       = ev_emit && full && !pop;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    overflow_d = drop ? 1'b1 : (bus.ovf_clr ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rx_valid_q  <= 1'b1;
      last_byte_q <= 8'h00;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_valid_q  <= bus.rx_valid;
      last_byte_q <= last_byte_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= {ext, brk, bus.rx_data};
  end

  assign bus.ev_data   = mem_q[rd_ptr_q];
  assign bus.ev_valid  = (count_q != '0);
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.last_byte = last_byte_q;
  assign bus.dec_state = state_q;

endmodule

// File: tb/tb_ps2_scancode_fifo.sv
// Bench for ps2_scancode_fifo: two instances (break events kept / filtered)
// share one stimulus stream and are checked against a prefix-flag queue model.
module tb_ps2_scancode_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  // Clock and reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_err   = 1'b0;
  logic       ev_ready = 1'b0;
  logic       ovf_clr  = 1'b0;

  ps2_scancode_fifo_if #(.AW(AW)) bus0 ();
  ps2_scancode_fifo_if #(.AW(AW)) bus1 ();

  assign bus0.rx_data  = rx_data;
  assign bus0.rx_valid = rx_valid;
  assign bus0.rx_err   = rx_err;
  assign bus0.ev_ready = ev_ready;
  assign bus0.ovf_clr  = ovf_clr;
  assign bus1.rx_data  = rx_data;
  assign bus1.rx_valid = rx_valid;
  assign bus1.rx_err   = rx_err;
  assign bus1.ev_ready = ev_ready;
  assign bus1.ovf_clr  = ovf_clr;

  ps2_scancode_fifo #(.DEPTH(DEPTH), .AW(AW), .FILTER_BREAK(1'b0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  ps2_scancode_fifo #(.DEPTH(DEPTH), .AW(AW), .FILTER_BREAK(1'b1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  logic [9:0]  act_data  [2];
  logic        act_valid [2];
  logic [AW:0] act_count [2];
  logic        act_ovf   [2];
  logic [7:0]  act_last  [2];

  assign act_data[0]  = bus0.ev_data;
  assign act_data[1]  = bus1.ev_data;
  assign act_valid[0] = bus0.ev_valid;
  assign act_valid[1] = bus1.ev_valid;
  assign act_count[0] = bus0.count;
  assign act_count[1] = bus1.count;
  assign act_ovf[0]   = bus0.overflow;
  assign act_ovf[1]   = bus1.overflow;
  assign act_last[0]  = bus0.last_byte;
  assign act_last[1]  = bus1.last_byte;

  // Reference model state
  logic [9:0] exp_q [2][$];
  logic       m_ovf [2];
  logic       pop_pending [2];
  logic       m_ext = 1'b0;
  logic       m_brk = 1'b0;
  logic       m_prev_v = 1'b1;
  logic [7:0] m_last = 8'h00;
  logic       started = 1'b0;
  logic       end_chk = 1'b0;
  logic       end_done = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int lane,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lane%0d t=%0t: got %h, expected %h", name, lane, $time, act, exp);
    end
  endtask

  // Model: runs late in the low clock phase, after the monitor has decided
  // whether the coming edge pops, and applies the coming edge's effects.
  always begin : model
    logic       acc, emit;
    logic [9:0] ev;
    int         occ;
    logic       drop;
    @(negedge clk);
    #4;
    if (reset) begin
      for (int l = 0; l < 2; l++) begin
        exp_q[l].delete();
        m_ovf[l] = 1'b0;
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
      m_prev_v = 1'b1;
      m_last = 8'h00;
      started = 1'b1;
    end else if (started) begin
      acc = rx_valid && !m_prev_v;
      m_prev_v = rx_valid;
      emit = 1'b0;
      ev = '0;
      if (acc) m_last = rx_data;
      if (rx_err) begin
        m_ext = 1'b0;
        m_brk = 1'b0;
      end else if (acc) begin
        if (rx_data == 8'hE0) m_ext = 1'b1;
        else if (rx_data == 8'hF0) m_brk = 1'b1;
        else begin
          if (rx_data != 8'h00 && rx_data != 8'hFF) begin
            emit = 1'b1;
            ev = {m_ext, m_brk, rx_data};
          end
          m_ext = 1'b0;
          m_brk = 1'b0;
        end
      end
      for (int l = 0; l < 2; l++) begin
        drop = 1'b0;
        if (emit && !(l == 1 && ev[8])) begin
          occ = exp_q[l].size() + (pop_pending[l] ? 1 : 0);
          if (occ < DEPTH || pop_pending[l]) exp_q[l].push_back(ev);
          else drop = 1'b1;
        end
        m_ovf[l] = drop ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf[l]);
      end
    end
  end

  // Scoreboard monitor: compares the settled DUT state and, when a pop is
  // about to happen, the head against the oldest expected event.
  always begin : monitor
    @(negedge clk);
    #3;
    for (int l = 0; l < 2; l++) pop_pending[l] = 1'b0;
    if (started) begin
      for (int l = 0; l < 2; l++) begin
        check("ev_valid", l, 32'(act_valid[l]), 32'(exp_q[l].size() != 0));
        check("count", l, 32'(act_count[l]), 32'(exp_q[l].size()));
        check("overflow", l, 32'(act_ovf[l]), 32'(m_ovf[l]));
        check("last_byte", l, 32'(act_last[l]), 32'(m_last));
        if (!reset && ev_ready && exp_q[l].size() != 0) begin
          pop_pending[l] = 1'b1;
          check("ev_data", l, 32'(act_data[l]), 32'(exp_q[l].pop_front()));
        end
      end
    end
    if (end_chk && !end_done) begin
      for (int l = 0; l < 2; l++) check("final_empty", l, 32'(exp_q[l].size()), 32'd0);
      end_done = 1'b1;
    end
  end

  // Driver tasks
  task automatic send(input logic [7:0] b, input logic pop_now = 1'b0);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    ev_ready = pop_now;
    @(negedge clk);
    rx_valid = 1'b0;
    ev_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    @(negedge clk);
    ev_ready = 1'b1;
    repeat (DEPTH + 3) @(negedge clk);
    ev_ready = 1'b0;
  endtask

  initial begin
    idle(3);
    reset = 1'b0;
    idle(2);

    send(8'h1C);
    idle(3);
    drain();

    send(8'hE0); send(8'hF0); send(8'h75);
    idle(2);
    drain();

    for (int i = 0; i < 9; i++) send(8'h10 + 8'(i));
    idle(2);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    send(8'h22, 1'b1);
    idle(2);
    drain();

    @(negedge clk); rx_data = 8'h1C; rx_valid = 1'b1;
    idle(5);
    rx_valid = 1'b0;
    drain();

    @(negedge clk); rx_data = 8'h1C; rx_valid = 1'b1; reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(3);
    rx_valid = 1'b0;
    idle(2);
    send(8'h1C);
    drain();

    send(8'hF0);
    @(negedge clk); rx_err = 1'b1;
    @(negedge clk); rx_err = 1'b0;
    send(8'h1C);
    send(8'hF0); send(8'hFF); send(8'h1C);
    @(negedge clk); rx_data = 8'h33; rx_valid = 1'b1; rx_err = 1'b1;
    @(negedge clk); rx_valid = 1'b0; rx_err = 1'b0;
    drain();

    repeat (600) begin
      @(negedge clk);
      if (!rx_valid) begin
        case ($urandom_range(0, 5))
          0: rx_data = 8'hE0;
          1: rx_data = 8'hF0;
          2: rx_data = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'hFF;
          default: rx_data = 8'($urandom_range(1, 254));
        endcase
      end
      rx_valid = ($urandom_range(0, 1) != 0);
      rx_err   = ($urandom_range(0, 24) == 0);
      ev_ready = ($urandom_range(0, 3) == 0);
      ovf_clr  = ($urandom_range(0, 15) == 0);
      reset    = ($urandom_range(0, 149) == 0);
    end

    @(negedge clk);
    reset = 1'b0; rx_valid = 1'b0; rx_err = 1'b0; ovf_clr = 1'b0;
    drain();
    end_chk = 1'b1;
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_fifo.md
Name: ps2_scancode_fifo

Overview:
- Parametrised successor to the single-byte PS/2 receive latch.
- Sits between the PS/2 line interface (byte + strobe) and game/control logic.
- Decodes scan-code set 2 prefixes (0xE0 extended, 0xF0 break) into complete key events and buffers them in a show-ahead FIFO with valid/ready pop handshake.
- Reports occupancy, sticky overflow and the raw last received byte.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- AW, 3, log2(DEPTH); must be set consistently with DEPTH.
- FILTER_BREAK, 0, 1 = break (key-release) events are decoded but never pushed.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  byte from PS/2 line interface; valid while rx_valid high.
- rx_valid  in  1  byte strobe from line interface; only its rising edge is acted on.
- rx_err  in  1  framing/parity error pulse from line interface.
- ev_data  out  10  head event {ext, brk, code[7:0]}; meaningful only when ev_valid=1.
- ev_valid  out  1  FIFO non-empty.
- ev_ready  in  1  consumer accepts head when ev_valid && ev_ready.
- count  out  AW+1  entries held, 0..DEPTH.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- ovf_clr  in  1  single-cycle clear of overflow.
- last_byte  out  8  last accepted raw byte, prefixes included.

Behaviour:
- Reset (synchronous, active-high), any time including mid-sequence:
  - ev_valid=0, count=0, overflow=0, last_byte=0x00; ev_data undefined but driven.
  - Decoder returns to IDLE; rd/wr pointers cleared.
  - Edge-detect register rx_valid_q resets to 1, so a strobe held high through reset is not accepted.
- Byte acceptance:
  - A byte is accepted on any edge where rx_valid=1 and rx_valid_q=0.
  - Holding rx_valid high accepts exactly one byte.
  - last_byte is loaded on that edge.
- Decoder states: IDLE, E0, F0, E0F0.
  - Accepted 0xE0: IDLE->E0, F0->E0F0; E0 and E0F0 hold.
  - Accepted 0xF0: IDLE->F0, E0->E0F0; F0 and E0F0 hold.
  - Accepted 0x00 or 0xFF (keyboard overrun): dropped, ->IDLE, no event.
  - Any other byte b: emit {ext, brk, b} with ext=1 in E0/E0F0 and brk=1 in F0/E0F0, then ->IDLE.
  - rx_err=1 on any edge: ->IDLE. If rx_valid rises on the same edge, rx_err wins: byte discarded, last_byte still updated.
  - FILTER_BREAK=1: events with brk=1 are not pushed; decoding is otherwise identical.
- FIFO:
  - An emitted event is written on the acceptance edge.
  - Latency: ev_valid rises in the cycle after the acceptance edge when starting empty; no combinational bypass.
  - Show-ahead: ev_data presents the head with no read latency.
  - Pop occurs on an edge where ev_valid && ev_ready; ev_ready while empty is ignored.
  - Push and pop on the same edge: count unchanged, both pointers advance.
  - Full (count=DEPTH) with push and no pop: event dropped, overflow<=1, contents unchanged.
  - Full with push and pop on the same edge: push succeeds, no overflow.
  - Pointers wrap modulo DEPTH; count is exact (AW+1 bits).
- Overflow flag:
  - Cleared by ovf_clr.
  - If a drop and ovf_clr occur on the same edge, overflow ends at 1 (set wins).

Test Plan:
- Reset, then bytes 0x1C -> one event ev_data=0x01C, count=1, last_byte=0x1C; ev_valid high exactly one cycle after acceptance edge.
- Sequence E0 F0 75 -> single event 0x375 (ext=1, brk=1); count=1; last_byte=0x75. With FILTER_BREAK=1 -> no event, count=0.
- DEPTH=8, ev_ready=0, push 9 plain codes 0x10..0x18 -> count=8, overflow=1; pops return 0x010..0x017 in order. ovf_clr -> overflow=0.
- FIFO full, 0x22 accepted on the same edge as a pop -> count stays 8, overflow stays 0, 0x022 last in pop order.
- rx_valid held high 5 cycles with 0x1C -> exactly one event. Reset asserted while rx_valid high, then released -> no event until rx_valid falls and rises again.
- F0 then rx_err pulse, then 0x1C -> event 0x01C (brk=0). F0, 0xFF, 0x1C -> event 0x01C, and 0xFF produces no event.
